// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared funct3 encodings, read-only field and FSM states for the CSR access unit
package csr_pkg;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

    // Addresses with this value in bits [11:10] are read-only CSRs
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_READ_ENC  = 2'd1;
    localparam logic [1:0] ST_WRITE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_READ  = ST_READ_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_DONE  = ST_DONE_ENC
    } csr_state_t;

endpackage

// File: rtl/csr_write_data_alu.sv
// rtl/csr_write_data_alu.sv - new CSR value from op, old value and source operand
module csr_write_data_alu
    import csr_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] old,
    input  logic [31:0] src,
    output logic [31:0] result
);

    always_comb begin
        result = src;
        case (op)
            CSR_RS, CSR_RSI: result = old | src;
            CSR_RC, CSR_RCI: result = old & ~src;
            default:         result = src;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - executes one Zicsr instruction as a read phase and a write phase on the CSR bus
module csr_access_unit
    import csr_pkg::*;
#(
    parameter logic READ_ONLY_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [11:0] csrAddress,
    input  logic [4:0]  rs1Index,
    input  logic [4:0]  rdIndex,
    input  logic [31:0] rs1Data,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [31:0] rdData,
    output logic        csrReadEnable,
    output logic [11:0] csrReadAddress,
    input  logic [31:0] csrReadData,
    output logic        csrWriteEnable,
    output logic [11:0] csrWriteAddress,
    output logic [31:0] csrWriteData
);

    csr_state_t  state, state_next;

    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [4:0]  rs1_idx_q;
    logic [4:0]  rd_idx_q;
    logic [31:0] rs1_data_q;
    logic [31:0] old_q;

    logic        in_idle;
    logic [2:0]  cur_op;
    logic [11:0] cur_addr;
    logic [4:0]  cur_rs1_idx;
    logic [4:0]  cur_rd_idx;
    logic [31:0] cur_rs1_data;
    logic [31:0] cur_src;
    logic [31:0] cur_old;
    logic        cur_do_read;
    logic        cur_do_write;
    logic        cur_illegal;
    logic [31:0] wr_value;

    // In IDLE the decode looks at the live inputs so the first phase can be
    // launched on the accepting edge; afterwards it looks at the latched copy.
    assign in_idle      = (state == ST_IDLE);
    assign cur_op       = in_idle ? funct3     : op_q;
    assign cur_addr     = in_idle ? csrAddress : addr_q;
    assign cur_rs1_idx  = in_idle ? rs1Index   : rs1_idx_q;
    assign cur_rd_idx   = in_idle ? rdIndex    : rd_idx_q;
    assign cur_rs1_data = in_idle ? rs1Data    : rs1_data_q;

    assign cur_src      = cur_op[2] ? {27'd0, cur_rs1_idx} : cur_rs1_data;
    assign cur_old      = (state == ST_READ) ? csrReadData : old_q;

    assign cur_do_read  = !(((cur_op == CSR_RW) || (cur_op == CSR_RWI)) && (cur_rd_idx == 5'd0));
    assign cur_do_write = !(((cur_op == CSR_RS) || (cur_op == CSR_RC) ||
                             (cur_op == CSR_RSI) || (cur_op == CSR_RCI)) && (cur_rs1_idx == 5'd0));
    assign cur_illegal  = (cur_op[1:0] == 2'b00) ||
                          (READ_ONLY_CHECK && cur_do_write && (cur_addr[11:10] == CSR_RO_FIELD));

    csr_write_data_alu u_alu (
        .op     (cur_op),
        .old    (cur_old),
        .src    (cur_src),
        .result (wr_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cur_illegal) begin
                        state_next = ST_DONE;
                    end else if (cur_do_read) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_READ:  state_next = cur_do_write ? ST_WRITE : ST_DONE;
            ST_WRITE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q            <= 3'd0;
            addr_q          <= 12'd0;
            rs1_idx_q       <= 5'd0;
            rd_idx_q        <= 5'd0;
            rs1_data_q      <= 32'd0;
            old_q           <= 32'd0;
            rdData          <= 32'd0;
            csrReadAddress  <= 12'd0;
            csrWriteAddress <= 12'd0;
            csrWriteData    <= 32'd0;
        end else begin
            if (in_idle && start) begin
                op_q       <= funct3;
                addr_q     <= csrAddress;
                rs1_idx_q  <= rs1Index;
                rd_idx_q   <= rdIndex;
                rs1_data_q <= rs1Data;
                old_q      <= 32'd0;
                rdData     <= 32'd0;
            end
            if (state == ST_READ) begin
                old_q <= csrReadData;
            end
            // Bus address/data registers only move when their phase begins
            if (in_idle && (state_next == ST_READ)) begin
                csrReadAddress <= cur_addr;
            end
            if (state_next == ST_WRITE) begin
                csrWriteAddress <= cur_addr;
                csrWriteData    <= wr_value;
            end
            if ((state != ST_DONE) && (state_next == ST_DONE)) begin
                rdData <= (cur_do_read && !cur_illegal) ? cur_old : 32'd0;
            end
        end
    end

    assign busy           = !in_idle;
    assign done           = (state == ST_DONE);
    assign illegal        = done && cur_illegal;
    assign csrReadEnable  = (state == ST_READ);
    assign csrWriteEnable = (state == ST_WRITE);

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
Initiator side of the core's CSR read/write interface; executes decoded Zicsr instructions (CSRRW/S/C and immediate forms) against the CSR register file. Accepts one instruction via a start/done handshake, sequences a read phase and a write phase on the CSR bus, and returns the old CSR value for rd. Sits between the execute stage and the CSR register file; drives csrRead*/csrWrite* and consumes csrReadData.

Parameters:
- READ_ONLY_CHECK, 1, when 1 a write to an address with bits [11:10]==2'b11 is reported illegal; when 0 the check is disabled.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request to execute one CSR instruction; sampled only in IDLE
- funct3  in  3  instruction funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csrAddress  in  12  target CSR address
- rs1Index  in  5  rs1 field; also the zimm value for the immediate forms
- rdIndex  in  5  rd field; used only for read suppression
- rs1Data  in  32  rs1 register value
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; instruction raised an invalid-instruction trap
- rdData  out  32  old CSR value; valid from done and held until the next accepted start
- csrReadEnable  out  1  read strobe
- csrReadAddress  out  12  read address
- csrReadData  in  32  combinational read data returned by the CSR file; 0 when the address is unmapped
- csrWriteEnable  out  1  write strobe
- csrWriteAddress  out  12  write address
- csrWriteData  out  32  write data

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy, done, illegal, csrReadEnable and csrWriteEnable are 0; rdData and all address/data outputs are 0.
- Capture: in IDLE with start=1, latch funct3, address, rs1Index, rdIndex and rs1Data.
- src is the zero-extended rs1Index when funct3[2]=1; otherwise rs1Data.
- doRead is 0 only for RW/RWI with rdIndex=0; it is 1 in every other case.
- doWrite is 0 only for RS/RC/RSI/RCI with rs1Index=0; it is 1 in every other case.
- Illegal conditions:
  - funct3 is 000 or 100; or
  - READ_ONLY_CHECK=1, doWrite=1 and address[11:10]==2'b11.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE -> DONE when the instruction is illegal.
  - IDLE -> READ when doRead=1.
  - IDLE -> WRITE when doRead=0 and doWrite=1.
  - READ -> WRITE when doWrite=1; otherwise READ -> DONE.
  - WRITE -> DONE.
  - DONE -> IDLE.
- READ (1 cycle): csrReadEnable=1 and csrReadAddress=latched address; csrReadData is registered into the old-value register at the clock edge.
- WRITE (1 cycle): csrWriteEnable=1 and csrWriteAddress=latched address.
  - RW/RWI: csrWriteData = src.
  - RS/RSI: csrWriteData = old | src.
  - RC/RCI: csrWriteData = old & ~src.
- DONE (1 cycle): done=1 and illegal=registered flag.
  - rdData = old when doRead=1; otherwise rdData = 0.
  - When illegal, neither strobe is asserted at any point and rdData = 0.
- Latency from the start cycle: read+write 3 cycles to done; read-only or write-only 2 cycles; illegal 1 cycle.
- No back-to-back acceptance: start is ignored outside IDLE, so the earliest next start is accepted in the cycle after done.
- Strobes are never asserted together; at most one read and at most one write per instruction.
- Address and data outputs hold their values while their strobe is low.
- Reset mid-operation: strobes drop immediately, no pending write completes, and done is not issued.

Decomposition:
- Shared package (csr_pkg) holds:
  - funct3 encoding constants (CSR_RW/RS/RC/RWI/RSI/RCI);
  - the read-only address field constant (2'b11 at bits [11:10]);
  - state encoding localparams.
- One natural sub-module, csr_write_data_alu: combinational computation of the write value from op, old and src.

Test Plan:
- Read+write: CSRRW, address 0x340, rs1Data=0xDEADBEEF, rdIndex=5, CSR holds 0x12345678 -> read strobe on cycle+1, write strobe on cycle+2 with data 0xDEADBEEF, done on cycle+3 with rdData=0x12345678.
- Set and clear: CSRRS with old=0x0000F000 and src=0x000000FF -> write 0x0000F0FF. CSRRCI with zimm=0x3 and old=0x0F -> write 0x0C.
- Read suppression: CSRRW with rdIndex=0 -> no read strobe, write on cycle+1, done on cycle+2 with rdData=0.
- Write suppression: CSRRS with rs1Index=0 on 0xC00 -> read only, no write strobe, done with the cycle count and illegal=0.
- Illegal cases: CSRRW to 0xF11 -> done on cycle+1 with illegal=1 and no strobes. funct3=100 -> same response. start held high while busy -> ignored.
- Reset mid-operation: assert rst in READ -> csrReadEnable drops without waiting for a clock edge. Release rst and issue a new start -> normal latency, no stale done.
